down_counter_timer: RTL

Programmable down-counting timer: the decrementing counterpart to the team's incrementing counter next-state logic. Counts from a loaded initial value down toward a terminal value, emitting a one-cycle `tick` on each terminal event. Reloads (periodic mode) or halts with `done` (one-shot mode). Used as the lab timer/prescaler block feeding FSMs that need countdown timeouts rather than free-running count-up ticks.

---
 rtl/down_counter_timer.sv | 106 ++++++++++
 1 files changed

// File: rtl/down_counter_timer.sv
// Programmable down-counting timer with one-shot and periodic modes.
// Emits a registered one-cycle tick on each terminal event.
module down_counter_timer #(
    parameter int NBITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [NBITS-1:0] cnt_ini,
    input  logic [NBITS-1:0] cnt_end,
    output logic [NBITS-1:0] q,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [NBITS-1:0] q_nx;
    logic [NBITS-1:0] ini_r;
    logic [NBITS-1:0] ini_nx;
    logic [NBITS-1:0] end_r;
    logic [NBITS-1:0] end_nx;
    logic             mode_r;
    logic             mode_nx;
    logic             tick_nx;
    logic [NBITS-1:0] dec;
    logic             hit;

    // Wrap from zero to all-ones is a legal step of the count.
    assign dec = q - NBITS'(1);
    assign hit = (dec == end_r);

    // Register state, count, tick and the values captured at start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            q      <= '0;
            tick   <= 1'b0;
            ini_r  <= '0;
            end_r  <= '0;
            mode_r <= 1'b0;
        end else begin
            state  <= state_nx;
            q      <= q_nx;
            tick   <= tick_nx;
            ini_r  <= ini_nx;
            end_r  <= end_nx;
            mode_r <= mode_nx;
        end
    end

    // Next-state logic: stop beats start, start beats a coincident hit.
    always_comb begin
        state_nx = state;
        q_nx     = q;
        tick_nx  = 1'b0;
        ini_nx   = ini_r;
        end_nx   = end_r;
        mode_nx  = mode_r;
        if (stop) begin
            state_nx = IDLE;
        end else if (start) begin
            state_nx = RUN;
            q_nx     = cnt_ini;
            ini_nx   = cnt_ini;
            end_nx   = cnt_end;
            mode_nx  = mode;
        end else begin
            unique case (state)
                RUN: begin
                    if (hit) begin
                        tick_nx = 1'b1;
                        if (mode_r) begin
                            q_nx = ini_r;
                        end else begin
                            q_nx     = end_r;
                            state_nx = DONE;
                        end
                    end else begin
                        q_nx = dec;
                    end
                end
                IDLE, DONE: begin
                    q_nx = q;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // Status flags come straight from the registered state.
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
